pcie_tx_arbiter: RTL and testbench

- Packet-level arbiter that shares the single 32-bit PCI-E core transmit AXI-Stream between two TLP sources: S0, the MicroBlaze TLP path, and S1, the internal completion/config engine.
- Sequences core-generated configuration traffic (tx_cfg_req/tx_cfg_gnt) against user packets.
- Gates packet starts on available TX buffers and link state.
- Drains orphaned packets on link loss and counts tx_err_drop events.
- Sits between the application logic and the s6_pcie transaction TX interface, in the user_clk domain.

---
 rtl/pcie_tx_arbiter_if.sv | 42 ++++
 rtl/pcie_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_arbiter_if.sv
// Transmit-side AXI-Stream bundle for pcie_tx_arbiter: two requester streams in, one core stream out.
// master = application/core side, slave = the arbiter.
interface pcie_tx_arbiter_if;
  logic        s0_axis_tvalid;
  logic        s0_axis_tready;
  logic        s0_axis_tlast;
  logic [31:0] s0_axis_tdata;
  logic [3:0]  s0_axis_tkeep;
  logic [3:0]  s0_axis_tuser;

  logic        s1_axis_tvalid;
  logic        s1_axis_tready;
  logic        s1_axis_tlast;
  logic [31:0] s1_axis_tdata;
  logic [3:0]  s1_axis_tkeep;
  logic [3:0]  s1_axis_tuser;

  logic        m_axis_tx_tvalid;
  logic        m_axis_tx_tready;
  logic        m_axis_tx_tlast;
  logic [31:0] m_axis_tx_tdata;
  logic [3:0]  m_axis_tx_tkeep;
  logic [3:0]  m_axis_tx_tuser;

  modport master (
    output s0_axis_tvalid, s0_axis_tlast, s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser,
    input  s0_axis_tready,
    output s1_axis_tvalid, s1_axis_tlast, s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser,
    input  s1_axis_tready,
    input  m_axis_tx_tvalid, m_axis_tx_tlast, m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tuser,
    output m_axis_tx_tready
  );

  modport slave (
    input  s0_axis_tvalid, s0_axis_tlast, s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser,
    output s0_axis_tready,
    input  s1_axis_tvalid, s1_axis_tlast, s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser,
    output s1_axis_tready,
    output m_axis_tx_tvalid, m_axis_tx_tlast, m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tuser,
    input  m_axis_tx_tready
  );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// Packet-level arbiter sharing the PCI-E core TX stream between two TLP sources, with
// core config-traffic sequencing, buffer/link start gating, link-loss drain and drop counting.
module pcie_tx_arbiter #(
  parameter int unsigned MIN_BUF_AV   = 2,
  parameter bit          CFG_PRIORITY = 1'b1
) (
  input  logic                     user_clk,
  input  logic                     user_reset,
  input  logic                     user_lnk_up,
  pcie_tx_arbiter_if.slave         axis,
  input  logic [5:0]               tx_buf_av,
  input  logic                     tx_cfg_req,
  output logic                     tx_cfg_gnt,
  input  logic                     tx_err_drop,
  output logic [15:0]              drop_count,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, GNT_CFG, PKT0, PKT1, DRAIN0, DRAIN1} state_t;

  localparam logic [5:0] MIN_BUF = 6'(MIN_BUF_AV);

  state_t state, next_state;
  logic   rr_last, rr_next;   // 0 = S0 served last, 1 = S1 served last
  logic   start_ok, any_valid;

  assign start_ok  = user_lnk_up && (tx_buf_av >= MIN_BUF);
  assign any_valid = axis.s0_axis_tvalid || axis.s1_axis_tvalid;

  always_comb begin
    next_state            = state;
    rr_next               = rr_last;
    axis.s0_axis_tready   = 1'b0;
    axis.s1_axis_tready   = 1'b0;
    axis.m_axis_tx_tvalid = 1'b0;
    axis.m_axis_tx_tlast  = 1'b0;
    axis.m_axis_tx_tdata  = '0;
    axis.m_axis_tx_tkeep  = '0;
    axis.m_axis_tx_tuser  = '0;

    case (state)
      IDLE: begin
        if (CFG_PRIORITY && tx_cfg_req) begin
          next_state = GNT_CFG;
        end else if (start_ok && any_valid) begin
          if (axis.s0_axis_tvalid && axis.s1_axis_tvalid)
            next_state = rr_last ? PKT0 : PKT1;
          else
            next_state = axis.s0_axis_tvalid ? PKT0 : PKT1;
        end else if (tx_cfg_req) begin
          next_state = GNT_CFG;
        end
      end
      GNT_CFG: begin
        if (!tx_cfg_req) next_state = IDLE;
      end
      PKT0: begin
        axis.m_axis_tx_tvalid = axis.s0_axis_tvalid;
        axis.m_axis_tx_tlast  = axis.s0_axis_tlast;
        axis.m_axis_tx_tdata  = axis.s0_axis_tdata;
        axis.m_axis_tx_tkeep  = axis.s0_axis_tkeep;
        axis.m_axis_tx_tuser  = axis.s0_axis_tuser;
        axis.s0_axis_tready   = axis.m_axis_tx_tready;
        // A closing beat wins over link loss: the packet is complete, no drain needed.
        if (axis.s0_axis_tvalid && axis.m_axis_tx_tready && axis.s0_axis_tlast) begin
          next_state = IDLE;
          rr_next    = 1'b0;
        end else if (!user_lnk_up) begin
          next_state = DRAIN0;
        end
      end
      PKT1: begin
        axis.m_axis_tx_tvalid = axis.s1_axis_tvalid;
        axis.m_axis_tx_tlast  = axis.s1_axis_tlast;
        axis.m_axis_tx_tdata  = axis.s1_axis_tdata;
        axis.m_axis_tx_tkeep  = axis.s1_axis_tkeep;
        axis.m_axis_tx_tuser  = axis.s1_axis_tuser;
        axis.s1_axis_tready   = axis.m_axis_tx_tready;
        if (axis.s1_axis_tvalid && axis.m_axis_tx_tready && axis.s1_axis_tlast) begin
          next_state = IDLE;
          rr_next    = 1'b1;
        end else if (!user_lnk_up) begin
          next_state = DRAIN1;
        end
      end
      DRAIN0: begin
        axis.s0_axis_tready = 1'b1;
        if (axis.s0_axis_tvalid && axis.s0_axis_tlast) begin
          next_state = IDLE;
          rr_next    = 1'b0;
        end
      end
      DRAIN1: begin
        axis.s1_axis_tready = 1'b1;
        if (axis.s1_axis_tvalid && axis.s1_axis_tlast) begin
          next_state = IDLE;
          rr_next    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase

    if (user_reset) begin
      axis.s0_axis_tready   = 1'b0;
      axis.s1_axis_tready   = 1'b0;
      axis.m_axis_tx_tvalid = 1'b0;
    end
  end

  // Grant and busy are registered from next_state so they line up with the state register.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      tx_cfg_gnt <= 1'b0;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      state      <= next_state;
      rr_last    <= rr_next;
      tx_cfg_gnt <= (next_state == GNT_CFG);
      busy       <= (next_state != IDLE);
      if (tx_err_drop && (drop_count != '1))
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed self-checking bench for pcie_tx_arbiter (MIN_BUF_AV=2, CFG_PRIORITY=1).
module tb_pcie_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        lnk;
  logic [5:0]  buf_av;
  logic        cfg_req;
  logic        cfg_gnt;
  logic        err_drop;
  logic [15:0] drop_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  pcie_tx_arbiter_if bus ();

  pcie_tx_arbiter #(.MIN_BUF_AV(2), .CFG_PRIORITY(1'b1)) dut (
    .user_clk    (clk),
    .user_reset  (rst),
    .user_lnk_up (lnk),
    .axis        (bus.slave),
    .tx_buf_av   (buf_av),
    .tx_cfg_req  (cfg_req),
    .tx_cfg_gnt  (cfg_gnt),
    .tx_err_drop (err_drop),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_s0(input logic v, input logic [31:0] d, input logic l);
    bus.s0_axis_tvalid = v;
    bus.s0_axis_tdata  = d;
    bus.s0_axis_tlast  = l;
  endtask

  task automatic drive_s1(input logic v, input logic [31:0] d, input logic l);
    bus.s1_axis_tvalid = v;
    bus.s1_axis_tdata  = d;
    bus.s1_axis_tlast  = l;
  endtask

  initial begin
    int p0, b0, p1, b1, ph, src, pk;
    logic [31:0] exp_d;
    logic hs0, hs1;

    rst = 1'b1; lnk = 1'b1; buf_av = 6'd10; cfg_req = 1'b0; err_drop = 1'b0;
    drive_s0(1'b0, '0, 1'b0);
    drive_s1(1'b0, '0, 1'b0);
    bus.s0_axis_tkeep = 4'hF; bus.s0_axis_tuser = 4'h5;
    bus.s1_axis_tkeep = 4'h3; bus.s1_axis_tuser = 4'hA;
    bus.m_axis_tx_tready = 1'b1;

    // Reset state
    tick; tick;
    drive_s0(1'b1, 32'h1111_1111, 1'b0);
    settle;
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", cfg_gnt, 1'b0);
    chk("rst_drop", drop_count, 16'h0);
    chk("rst_s0_tready", bus.s0_axis_tready, 1'b0);
    chk("rst_m_tvalid", bus.m_axis_tx_tvalid, 1'b0);

    // Single S0 4-beat packet: one cycle of arbitration latency, then pass-through
    rst = 1'b0;
    settle;
    chk("t1_idle_m_tvalid", bus.m_axis_tx_tvalid, 1'b0);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive_s0(1'b1, 32'h1111_1111 * (i + 1), i == 3);
      settle;
      chk("t1_m_tvalid", bus.m_axis_tx_tvalid, 1'b1);
      chk("t1_m_tdata", bus.m_axis_tx_tdata, 32'h1111_1111 * (i + 1));
      chk("t1_m_tlast", bus.m_axis_tx_tlast, i == 3);
      chk("t1_s0_tready", bus.s0_axis_tready, 1'b1);
      chk("t1_s1_tready", bus.s1_axis_tready, 1'b0);
      chk("t1_busy", busy, 1'b1);
      tick;
    end
    chk("t1_m_tkeep_tuser", {28'h0, bus.m_axis_tx_tkeep}, 32'h0);
    drive_s0(1'b0, '0, 1'b0);
    settle;
    chk("t1_end_busy", busy, 1'b0);
    chk("t1_end_m_tvalid", bus.m_axis_tx_tvalid, 1'b0);

    // Both requesters offer 3-beat packets continuously: S0,S1,S0,S1 with one idle cycle per handoff
    rst = 1'b1; tick; rst = 1'b0;
    p0 = 0; b0 = 0; p1 = 0; b1 = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      drive_s0(1'b1, 32'hA000_0000 | 32'(p0 << 4) | 32'(b0), b0 == 2);
      drive_s1(1'b1, 32'hB000_0000 | 32'(p1 << 4) | 32'(b1), b1 == 2);
      settle;
      ph  = cyc % 4;
      src = (cyc / 4) % 2;
      pk  = cyc / 8;
      if (ph == 0) begin
        chk("t2_gap_m_tvalid", bus.m_axis_tx_tvalid, 1'b0);
      end else begin
        exp_d = (src == 1 ? 32'hB000_0000 : 32'hA000_0000) | 32'(pk << 4) | 32'(ph - 1);
        chk("t2_m_tvalid", bus.m_axis_tx_tvalid, 1'b1);
        chk("t2_m_tdata", bus.m_axis_tx_tdata, exp_d);
        chk("t2_m_tuser", bus.m_axis_tx_tuser, src == 1 ? 4'hA : 4'h5);
      end
      hs0 = bus.s0_axis_tready;
      hs1 = bus.s1_axis_tready;
      if (hs0) begin b0++; if (b0 == 3) begin b0 = 0; p0++; end end
      if (hs1) begin b1++; if (b1 == 3) begin b1 = 0; p1++; end end
      tick;
    end
    drive_s0(1'b0, '0, 1'b0);
    drive_s1(1'b0, '0, 1'b0);
    chk("t2_s0_packets", p0, 2);
    chk("t2_s1_packets", p1, 2);

    // tx_cfg_req raised mid S1 packet is held off until the packet ends
    drive_s1(1'b1, 32'hC000_0000, 1'b0);
    settle;
    chk("t3_idle_gnt", cfg_gnt, 1'b0);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive_s1(1'b1, 32'hC000_0000 | 32'(i), i == 3);
      cfg_req = (i >= 1);
      settle;
      chk("t3_s1_tready", bus.s1_axis_tready, 1'b1);
      chk("t3_m_tdata", bus.m_axis_tx_tdata, 32'hC000_0000 | 32'(i));
      chk("t3_gnt_held", cfg_gnt, 1'b0);
      tick;
    end
    drive_s1(1'b0, '0, 1'b0);
    settle;
    chk("t3_idle_gnt_low", cfg_gnt, 1'b0);
    chk("t3_idle_busy", busy, 1'b0);
    tick;
    settle;
    chk("t3_gnt_high", cfg_gnt, 1'b1);
    chk("t3_gnt_busy", busy, 1'b1);
    chk("t3_gnt_m_tvalid", bus.m_axis_tx_tvalid, 1'b0);
    tick;
    cfg_req = 1'b0;
    settle;
    chk("t3_gnt_hold", cfg_gnt, 1'b1);
    tick;
    settle;
    chk("t3_gnt_release", cfg_gnt, 1'b0);
    chk("t3_release_busy", busy, 1'b0);

    // Simultaneous cfg and both requesters: cfg first, then S0 (rr_last=S1), single-beat packets
    cfg_req = 1'b1;
    drive_s0(1'b1, 32'hD000_0000, 1'b1);
    drive_s1(1'b1, 32'hE000_0000, 1'b1);
    tick;
    settle;
    chk("t4_gnt", cfg_gnt, 1'b1);
    chk("t4_gnt_s0_tready", bus.s0_axis_tready, 1'b0);
    chk("t4_gnt_m_tvalid", bus.m_axis_tx_tvalid, 1'b0);
    cfg_req = 1'b0;
    tick;
    settle;
    chk("t4_idle_gnt", cfg_gnt, 1'b0);
    tick;
    settle;
    chk("t4_rr_s0_tready", bus.s0_axis_tready, 1'b1);
    chk("t4_rr_s1_tready", bus.s1_axis_tready, 1'b0);
    chk("t4_m_tdata_s0", bus.m_axis_tx_tdata, 32'hD000_0000);
    chk("t4_m_tlast", bus.m_axis_tx_tlast, 1'b1);
    tick;
    drive_s0(1'b0, '0, 1'b0);
    settle;
    chk("t4_gap", bus.m_axis_tx_tvalid, 1'b0);
    tick;
    settle;
    chk("t4_m_tdata_s1", bus.m_axis_tx_tdata, 32'hE000_0000);
    chk("t4_s1_tready", bus.s1_axis_tready, 1'b1);
    tick;
    drive_s1(1'b0, '0, 1'b0);

    // tx_buf_av below threshold stalls the start; once started, never gated
    buf_av = 6'd1;
    drive_s0(1'b1, 32'hF000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("t5_stall_s0_tready", bus.s0_axis_tready, 1'b0);
      chk("t5_stall_busy", busy, 1'b0);
      tick;
    end
    buf_av = 6'd2;
    settle;
    chk("t5_thresh_idle", busy, 1'b0);
    tick;
    buf_av = 6'd0;
    settle;
    chk("t5_start_busy", busy, 1'b1);
    chk("t5_start_m_tdata", bus.m_axis_tx_tdata, 32'hF000_0000);
    tick;
    drive_s0(1'b1, 32'hF000_0001, 1'b1);
    settle;
    chk("t5_nogate_m_tvalid", bus.m_axis_tx_tvalid, 1'b1);
    chk("t5_nogate_s0_tready", bus.s0_axis_tready, 1'b1);
    tick;
    drive_s0(1'b0, '0, 1'b0);
    buf_av = 6'd10;
    settle;
    chk("t5_end_busy", busy, 1'b0);

    // Link loss after beat 1 of a 5-beat packet: remaining beats drained
    drive_s0(1'b1, 32'h5000_0000, 1'b0);
    tick;
    lnk = 1'b0;
    settle;
    chk("t6_beat1_m_tvalid", bus.m_axis_tx_tvalid, 1'b1);
    chk("t6_beat1_m_tdata", bus.m_axis_tx_tdata, 32'h5000_0000);
    tick;
    for (int i = 1; i < 5; i++) begin
      drive_s0(1'b1, 32'h5000_0000 | 32'(i), i == 4);
      settle;
      chk("t6_drain_s0_tready", bus.s0_axis_tready, 1'b1);
      chk("t6_drain_m_tvalid", bus.m_axis_tx_tvalid, 1'b0);
      chk("t6_drain_busy", busy, 1'b1);
      tick;
    end
    drive_s0(1'b1, 32'h6000_0000, 1'b1);
    settle;
    chk("t6_idle_busy", busy, 1'b0);
    tick;
    settle;
    chk("t6_nolink_busy", busy, 1'b0);
    chk("t6_nolink_s0_tready", bus.s0_axis_tready, 1'b0);
    lnk = 1'b1;
    tick;
    settle;
    chk("t6_relink_m_tvalid", bus.m_axis_tx_tvalid, 1'b1);
    chk("t6_relink_m_tdata", bus.m_axis_tx_tdata, 32'h6000_0000);
    tick;
    drive_s0(1'b0, '0, 1'b0);

    // drop_count: three pulses, then saturation at 0xFFFF
    err_drop = 1'b1;
    tick; tick; tick;
    err_drop = 1'b0;
    settle;
    chk("t7_drop3", drop_count, 16'd3);
    err_drop = 1'b1;
    repeat (65532) tick;
    err_drop = 1'b0;
    settle;
    chk("t7_drop_max", drop_count, 16'hFFFF);
    err_drop = 1'b1;
    repeat (5) tick;
    err_drop = 1'b0;
    settle;
    chk("t7_drop_sat", drop_count, 16'hFFFF);

    // Reset mid-packet: immediate abandon, no drain
    drive_s0(1'b1, 32'h7000_0000, 1'b0);
    tick;
    settle;
    chk("t8_pkt_m_tvalid", bus.m_axis_tx_tvalid, 1'b1);
    rst = 1'b1;
    settle;
    chk("t8_rst_m_tvalid", bus.m_axis_tx_tvalid, 1'b0);
    chk("t8_rst_s0_tready", bus.s0_axis_tready, 1'b0);
    tick;
    rst = 1'b0;
    settle;
    chk("t8_after_busy", busy, 1'b0);
    chk("t8_after_s0_tready", bus.s0_axis_tready, 1'b0);
    chk("t8_after_drop", drop_count, 16'h0);
    tick;
    drive_s0(1'b1, 32'h7000_0000, 1'b1);
    settle;
    chk("t8_restart_m_tvalid", bus.m_axis_tx_tvalid, 1'b1);
    tick;
    drive_s0(1'b0, '0, 1'b0);
    settle;
    chk("t8_end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
